// File: rtl/dconv_pkg.sv
// Shared constants for the depthwise-conv line buffer and its PE neighbour.
package dconv_pkg;

  // Default geometry and pixel width.
  localparam int unsigned INPUT_WIDTH = 8;
  localparam int unsigned IMG_WIDTH   = 32;
  localparam int unsigned IMG_HEIGHT  = 32;

  // Lane positions inside the packed 3-pixel column; the PE unpacks with the same indices.
  localparam int unsigned LANE_NEW  = 0;
  localparam int unsigned LANE_MID  = 1;
  localparam int unsigned LANE_OLD  = 2;
  localparam int unsigned NUM_LANES = 3;

endpackage

// File: rtl/dconv_line_buffer_if.sv
// Pixel-in / column-out stream bundle for the line buffer.
// master drives pixels and consumes columns; slave is the line buffer.
interface dconv_line_buffer_if
  import dconv_pkg::*;
#(
  parameter int unsigned input_width = INPUT_WIDTH
);

  logic [input_width-1:0]           pix_in;
  logic                             pix_valid;
  logic                             pix_ready;
  logic [NUM_LANES*input_width-1:0] image;
  logic                             image_valid;
  logic                             image_ready;
  logic                             input_last;
  logic                             frame_last;

  modport master (
    output pix_in, pix_valid, image_ready,
    input  pix_ready, image, image_valid, input_last, frame_last
  );

  modport slave (
    input  pix_in, pix_valid, image_ready,
    output pix_ready, image, image_valid, input_last, frame_last
  );

endinterface

// File: rtl/dconv_row_fifo.sv
// One image row of pixel storage: combinational read at i_col, write at the same column.
// A same-cycle write does not affect the read, so the caller sees the old row value.
module dconv_row_fifo
  import dconv_pkg::*;
#(
  parameter int unsigned input_width = INPUT_WIDTH,
  parameter int unsigned img_width   = IMG_WIDTH,
  parameter int unsigned col_bits    = $clog2(img_width)
) (
  input  logic                   clk,
  input  logic [col_bits-1:0]    i_col,
  input  logic                   i_wr_en,
  input  logic [input_width-1:0] i_wr_data,
  output logic [input_width-1:0] o_rd_data
);

  // Contents are not reset: the first two rows of every frame refill them before use.
  logic [input_width-1:0] r_mem [img_width];

  assign o_rd_data = r_mem[i_col];

  // Store the incoming pixel for this column.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_col] <= i_wr_data;
    end
  end

endmodule

// File: rtl/dconv_line_buffer.sv
// Raster pixel stream to 3-row vertical columns for the 3x3 depthwise-conv PE.
module dconv_line_buffer
  import dconv_pkg::*;
#(
  parameter int unsigned input_width = INPUT_WIDTH,
  parameter int unsigned img_width   = IMG_WIDTH,
  parameter int unsigned img_height  = IMG_HEIGHT,
  parameter int unsigned col_bits    = $clog2(img_width),
  parameter int unsigned row_bits    = $clog2(img_height)
) (
  input logic                clk,
  input logic                rst,
  dconv_line_buffer_if.slave bus
);

  localparam logic [col_bits-1:0] ColLast  = col_bits'(img_width - 1);
  localparam logic [row_bits-1:0] RowLast  = row_bits'(img_height - 1);
  localparam logic [row_bits-1:0] RowFirst = row_bits'(2);

  logic [col_bits-1:0]              r_col;
  logic [row_bits-1:0]              r_row;
  logic [NUM_LANES*input_width-1:0] r_image;
  logic                             r_valid;
  logic                             r_input_last;
  logic                             r_frame_last;

  logic                   w_accept;
  logic                   w_xfer;
  logic                   w_emit;
  logic                   w_col_last;
  logic                   w_row_last;
  logic [input_width-1:0] w_row_mid;
  logic [input_width-1:0] w_row_old;

  // Single output register: a new pixel is taken only if the held column leaves this cycle.
  assign bus.pix_ready   = !r_valid || bus.image_ready;
  assign bus.image       = r_image;
  assign bus.image_valid = r_valid;
  assign bus.input_last  = r_input_last;
  assign bus.frame_last  = r_frame_last;

  assign w_accept   = bus.pix_valid && bus.pix_ready;
  assign w_xfer     = r_valid && bus.image_ready;
  assign w_emit     = r_row >= RowFirst;
  assign w_col_last = r_col == ColLast;
  assign w_row_last = r_row == RowLast;

  // lb0 holds row r-1; its old value shifts into lb1, which holds row r-2.
  dconv_row_fifo #(
    .input_width (input_width),
    .img_width   (img_width),
    .col_bits    (col_bits)
  ) u_lb0 (
    .clk       (clk),
    .i_col     (r_col),
    .i_wr_en   (w_accept),
    .i_wr_data (bus.pix_in),
    .o_rd_data (w_row_mid)
  );

  dconv_row_fifo #(
    .input_width (input_width),
    .img_width   (img_width),
    .col_bits    (col_bits)
  ) u_lb1 (
    .clk       (clk),
    .i_col     (r_col),
    .i_wr_en   (w_accept),
    .i_wr_data (w_row_mid),
    .o_rd_data (w_row_old)
  );

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + row_bits'(1);
      end else begin
        r_col <= r_col + col_bits'(1);
      end
    end
  end

  // Output column register: load on an emitting accept, otherwise drain on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_image      <= '0;
      r_valid      <= 1'b0;
      r_input_last <= 1'b0;
      r_frame_last <= 1'b0;
    end else if (w_accept && w_emit) begin
      r_image[LANE_NEW*input_width +: input_width] <= bus.pix_in;
      r_image[LANE_MID*input_width +: input_width] <= w_row_mid;
      r_image[LANE_OLD*input_width +: input_width] <= w_row_old;
      r_valid      <= 1'b1;
      r_input_last <= w_col_last;
      r_frame_last <= w_col_last && w_row_last;
    end else if (w_xfer) begin
      // A non-emitting accept implies any pending column transferred, so this covers it too.
      r_valid      <= 1'b0;
      r_input_last <= 1'b0;
      r_frame_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dconv_line_buffer.sv
// Directed bench for dconv_line_buffer on a 4x4 image.
module tb_dconv_line_buffer;
  import dconv_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned IH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  // {frame_last, input_last, image} of every transferred column
  logic [25:0] cap_q[$];

  always #5 clk = ~clk;

  dconv_line_buffer_if #(.input_width(W)) bus ();

  dconv_line_buffer #(
    .input_width (W),
    .img_width   (IW),
    .img_height  (IH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) begin
    if (!rst && bus.image_valid && bus.image_ready) begin
      cap_q.push_back({bus.frame_last, bus.input_last, bus.image});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected column for output pixel (r, c) of a frame whose pixels are base + r*16 + c.
  function automatic logic [25:0] exp_col(input int r, input int c, input int base);
    logic [7:0] o;
    logic [7:0] m;
    logic [7:0] n;
    o = 8'(base + (r - 2) * 16 + c);
    m = 8'(base + (r - 1) * 16 + c);
    n = 8'(base + r * 16 + c);
    return {(r == IH - 1) && (c == IW - 1), c == IW - 1, o, m, n};
  endfunction

  task automatic push(input logic [7:0] p, input logic rdy);
    bus.pix_valid   = 1'b1;
    bus.pix_in      = p;
    bus.image_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pix_valid   = 1'b0;
    bus.image_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.pix_valid   = 1'b0;
    bus.pix_in      = '0;
    bus.image_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cap_q.delete();
  endtask

  // Stream one whole frame; optionally check the registered output after every accept.
  task automatic push_frame(input int base, input bit check, input bit gapped);
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        push(8'(base + r * 16 + c), 1'b1);
        if (check) begin
          chk("valid_after_accept", {31'd0, bus.image_valid}, {31'd0, r >= 2});
          if (r >= 2) begin
            chk("col_after_accept", {6'd0, bus.frame_last, bus.input_last, bus.image},
                {6'd0, exp_col(r, c, base)});
          end
        end
        if (gapped) begin
          idle();
          chk("valid_in_gap", {31'd0, bus.image_valid}, 32'd0);
        end
      end
    end
  endtask

  task automatic check_queue(input string tag, input int offset, input int base);
    for (int i = 0; i < 8; i++) begin
      if (offset + i < cap_q.size()) begin
        chk(tag, {6'd0, cap_q[offset + i]}, {6'd0, exp_col(2 + i / IW, i % IW, base)});
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.pix_valid   = 1'b0;
    bus.pix_in      = '0;
    bus.image_ready = 1'b1;
    @(posedge clk);
    #1;
    // Reset state
    chk("rst_pix_ready", {31'd0, bus.pix_ready}, 32'd1);
    chk("rst_image", {8'd0, bus.image}, 32'd0);
    chk("rst_valid", {31'd0, bus.image_valid}, 32'd0);
    chk("rst_flags", {30'd0, bus.input_last, bus.frame_last}, 32'd0);
    rst = 1'b0;
    cap_q.delete();

    // Continuous stream, no backpressure
    push_frame(0, 1'b1, 1'b0);
    idle();
    chk("s1_valid_drain", {31'd0, bus.image_valid}, 32'd0);
    chk("s1_count", cap_q.size(), 32'd8);
    check_queue("s1_col", 0, 0);
    if (cap_q.size() == 8) begin
      chk("s1_first", {8'd0, cap_q[0][23:0]}, 32'h001020);
      chk("s1_last", {6'd0, cap_q[7]}, {6'd0, 2'b11, 24'h132333});
    end

    // image_ready 1,0,0,1 during row 2
    do_reset();
    for (int i = 0; i < 8; i++) push(8'((i / 4) * 16 + i % 4), 1'b1);
    push(8'h20, 1'b1);
    chk("s2_first", {8'd0, bus.image}, 32'h001020);
    for (int s = 0; s < 2; s++) begin
      bus.pix_valid   = 1'b1;
      bus.pix_in      = 8'h21;
      bus.image_ready = 1'b0;
      #1;
      chk("s2_stall_pix_ready", {31'd0, bus.pix_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("s2_hold_image", {8'd0, bus.image}, 32'h001020);
      chk("s2_hold_valid", {31'd0, bus.image_valid}, 32'd1);
      chk("s2_hold_il", {31'd0, bus.input_last}, 32'd0);
    end
    push(8'h21, 1'b1);
    chk("s2_after_stall", {8'd0, bus.image}, 32'h011121);
    push(8'h22, 1'b1);
    push(8'h23, 1'b1);
    for (int c = 0; c < 4; c++) push(8'(8'h30 + c), 1'b1);
    idle();
    chk("s2_count", cap_q.size(), 32'd8);
    check_queue("s2_col", 0, 0);

    // Two back-to-back frames
    do_reset();
    push_frame(0, 1'b0, 1'b0);
    push_frame(8'h80, 1'b1, 1'b0);
    idle();
    chk("s3_count", cap_q.size(), 32'd16);
    check_queue("s3_f1", 0, 0);
    check_queue("s3_f2", 8, 8'h80);
    if (cap_q.size() == 16) begin
      chk("s3_f2_first", {8'd0, cap_q[8][23:0]}, 32'h8090A0);
      chk("s3_f2_last", {6'd0, cap_q[15]}, {6'd0, 2'b11, 24'h93A3B3});
    end

    // Reset after row 2 col 1 accepted
    do_reset();
    for (int i = 0; i < 8; i++) push(8'((i / 4) * 16 + i % 4), 1'b1);
    push(8'h20, 1'b1);
    push(8'h21, 1'b1);
    chk("s4_pre_valid", {31'd0, bus.image_valid}, 32'd1);
    rst           = 1'b1;
    bus.pix_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("s4_rst_image", {8'd0, bus.image}, 32'd0);
    chk("s4_rst_valid", {31'd0, bus.image_valid}, 32'd0);
    chk("s4_rst_flags", {30'd0, bus.input_last, bus.frame_last}, 32'd0);
    chk("s4_rst_pix_ready", {31'd0, bus.pix_ready}, 32'd1);
    rst = 1'b0;
    cap_q.delete();
    push_frame(0, 1'b1, 1'b0);
    idle();
    chk("s4_count", cap_q.size(), 32'd8);
    check_queue("s4_col", 0, 0);

    // Gapped pix_valid
    do_reset();
    push_frame(0, 1'b1, 1'b1);
    chk("s5_count", cap_q.size(), 32'd8);
    check_queue("s5_col", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
